ram_dp_be: RTL
==============

Name: ram_dp_be

Overview:
- Parametrised simple-dual-port RAM: one write port and one read port, sharing a single clock.
- Write port has per-byte write enables.
- Read port is synchronous: registered output plus a valid flag.
- Includes a post-reset clear sweep that zeroes every word before accepting traffic.
- Successor to the single-port async-read RAM; used as data memory and as a generic buffer inside the CPU.

Parameters:
- N, 6: address width; depth = 2**N words.
- M, 32: data width in bits; must be a multiple of 8; byte lanes B = M/8.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write request.
- be  in  M/8  byte enables; bit i controls din[8i+7:8i].
- wadr  in  N  write address.
- din  in  M  write data.
- re  in  1  read request.
- radr  in  N  read address.
- dout  out  M  registered read data.
- dout_valid  out  1  high exactly one cycle after an accepted read.
- busy  out  1  high while the clear sweep runs; requests are ignored while high.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - dout=0, dout_valid=0, busy=1, clear counter=0, state=ST_CLEAR.
  - Memory array is not reset by rst_n.
- ST_CLEAR:
  - Each cycle writes all-zero to mem[counter] and increments the counter.
  - On the cycle the counter reaches 2**N-1: that write occurs, next state=ST_RUN, busy drops to 0 in that same posedge update.
  - Sweep length is exactly 2**N cycles after rst_n deasserts.
  - we/re are ignored; dout_valid stays 0.
- ST_RUN:
  - Write: when we=1, for each i with be[i]=1, mem[wadr] lane i <= din lane i. Lanes with be[i]=0 keep their old value. we=1 with be=0 is a no-op.
  - Read: when re=1, dout <= mem[radr] and dout_valid <= 1 on the same posedge. Latency is 1 cycle.
  - When re=0: dout holds its last value and dout_valid <= 0.
  - Same-cycle read and write to the same address (write-first): enabled lanes of dout take din; other lanes take old memory contents.
  - Reads and writes to different addresses are fully independent, one of each per cycle.
- Reset mid-sweep or mid-operation: returns to ST_CLEAR and restarts the sweep from address 0. Outputs are as at reset.
- No other states exist. Illegal state encoding recovers to ST_CLEAR.

Optional Feature:
- Macro: RAM_CLEAR_EN.
- Defined: clear sweep as above.
- Undefined:
  - No ST_CLEAR and no counter; busy is tied to 0.
  - Block enters ST_RUN directly when rst_n deasserts.
  - Memory contents are undefined until written.
  - dout and dout_valid still reset to 0.

Decomposition:
- Package ram_pkg:
  - typedef enum logic {ST_CLEAR, ST_RUN} ram_state_t
  - localparam BYTE_W = 8
  - function computing lane count from M
- One sub-module, ram_clear_fsm:
  - Owns state and clear counter.
  - Outputs busy, clr_we, clr_adr.
  - Parametrised by N.
- Top level muxes the clear write against the user write port.

Test Plan (N=4, M=32):
1. Reset clear: release rst_n, then count cycles. Expected: busy=1 for exactly 16 cycles, then 0. Reading addresses 0..15 afterwards returns 32'h0000_0000 with dout_valid one cycle after each re.
2. Byte-enable write: write wadr=3, din=32'hAABBCCDD, be=4'b1111. Then write wadr=3, din=32'h11223344, be=4'b0101. Read radr=3. Expected: dout=32'hAA22CC44 one cycle after re.
3. Write-first collision: mem[5]=32'h00000000. Same cycle: we=1, wadr=5, din=32'hDEADBEEF, be=4'b1100, re=1, radr=5. Expected next cycle: dout=32'hDEAD0000, dout_valid=1.
4. Requests during sweep: assert we=1 (wadr=2, din=32'hFFFFFFFF) and re=1 every cycle while busy=1. Expected: dout_valid stays 0. After the sweep, reading radr=2 returns 0.
5. Reset mid-operation: write mem[7]=32'h12345678, then pulse rst_n low for 1 cycle. Expected: dout=0 and dout_valid=0 immediately (asynchronous), busy=1 for 16 cycles, and mem[7] then reads 0.
6. RAM_CLEAR_EN undefined: busy=0 from reset. Write wadr=0, din=32'h0000_00A5, be=4'b0001 on the first cycle after rst_n deasserts, then read radr=0. Expected: low byte reads 8'hA5.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM and its clear sequencer.
package ram_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} ram_state_t;

    localparam int BYTE_W = 8;

    function automatic int lane_count(input int m);
        return m / BYTE_W;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once, writing zero, then parks in ST_RUN.
// Only instantiated when RAM_CLEAR_EN is defined.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         busy,
    output logic         clr_we,
    output logic [N-1:0] clr_adr
);

    localparam logic [N-1:0] CNT_ONE = 1;
    localparam logic [N-1:0] CNT_MAX = '1;

    ram_state_t   state, state_nxt;
    logic [N-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // busy follows the registered state, so it falls on the same edge that writes the last word
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy    = 1'b1;
                clr_we  = 1'b1;
                cnt_nxt = cnt + CNT_ONE;
                if (cnt == CNT_MAX) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign clr_adr = cnt;

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM, one clock: byte-enabled write port, registered write-first read port.
// Define RAM_CLEAR_EN to zero the whole array after reset before traffic is accepted.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int N = 6,
    parameter int M = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [lane_count(M)-1:0] be,
    input  logic [N-1:0]             wadr,
    input  logic [M-1:0]             din,
    input  logic                     re,
    input  logic [N-1:0]             radr,
    output logic [M-1:0]             dout,
    output logic                     dout_valid,
    output logic                     busy
);

    localparam int B     = lane_count(M);
    localparam int DEPTH = 2 ** N;

    logic [M-1:0] mem [DEPTH];
    logic         clr_we;
    logic [N-1:0] clr_adr;
    logic         wr_en;
    logic         rd_en;
    logic [M-1:0] rd_word_p0;

`ifdef RAM_CLEAR_EN
    ram_clear_fsm #(
        .N (N)
    ) u_clear_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_adr (clr_adr)
    );
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_adr = '0;
`endif

    assign wr_en = we & ~busy;
    assign rd_en = re & ~busy;

    // Array carries no reset; the clear sweep owns the write port while busy
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_adr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < B; i++) begin
                if (be[i]) begin
                    mem[wadr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Write-first bypass: enabled lanes of a same-address write override the stored word
    always_comb begin
        rd_word_p0 = mem[radr];
        for (int i = 0; i < B; i++) begin
            if (wr_en && be[i] && (wadr == radr)) begin
                rd_word_p0[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read stage boundary: dout holds its value when no read is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_en;
            if (rd_en) begin
                dout <= rd_word_p0;
            end
        end
    end

endmodule
